// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSN_W       = 32;
    localparam int WORD_STEP    = 4;
    localparam int FETCH_ADDR_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSN_W-1:0]       insn;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched words and their PCs; head is read combinationally.
// Flush wins over push; the caller must only push when not full or when popping.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, buffers responses,
// handles redirects. Define FETCH_PERF_EN to add the o_perf_stall counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_running,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_insn_valid,
    output logic [31:0]       o_insn,
    output logic [ADDR_W-1:0] o_insn_pc,
    input  logic              i_insn_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       o_perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W:0]    in_flight;
    logic              granted;
    logic              rsp_drop;
    logic              rsp_accept;

    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign redirect_target = i_redirect_pc & ~ADDR_W'(3);

    // Words in flight plus words buffered may never exceed the FIFO size.
    assign in_flight  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign o_mem_req  = !i_reset && i_running && !i_redirect
                        && (in_flight < (CNT_W + 1)'(DEPTH));
    assign o_mem_addr = fetch_pc;
    assign granted    = o_mem_req && i_mem_gnt;

    assign outstanding_next = outstanding + CNT_W'(granted) - CNT_W'(i_mem_rvalid);

    assign rsp_drop   = i_mem_rvalid && (discard != '0);
    assign rsp_accept = i_mem_rvalid && (discard == '0) && !i_redirect;

    assign push_entry.insn = i_mem_rdata;
    assign push_entry.pc   = FETCH_ADDR_W'(resp_pc);
    assign fifo_push       = rsp_accept && (!fifo_full || fifo_pop);
    assign fifo_pop        = o_insn_valid && i_insn_ready;

    assign o_insn_valid = !fifo_empty;
    assign o_insn       = o_insn_valid ? head_entry.insn : '0;
    assign o_insn_pc    = o_insn_valid ? ADDR_W'(head_entry.pc) : '0;

    // On redirect, everything still in flight after this cycle becomes stale.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (i_redirect) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                discard  <= outstanding_next;
            end else begin
                if (granted) begin
                    fetch_pc <= fetch_pc + ADDR_W'(WORD_STEP);
                end
                if (rsp_accept) begin
                    resp_pc <= resp_pc + ADDR_W'(WORD_STEP);
                end
                if (rsp_drop) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (i_reset),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .flush (i_redirect),
        .rdata (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef FETCH_PERF_EN
    // Counts cycles the core was ready but had nothing to consume.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_perf_stall <= '0;
        end else if (i_running && i_insn_ready && !o_insn_valid
                     && (o_perf_stall != 32'hFFFF_FFFF)) begin
            o_perf_stall <= o_perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order memory model.
// Build with FETCH_PERF_EN defined to also exercise o_perf_stall.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        running;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall;
`endif

    int          errors;
    int          checks;
    int          lat;
    int          grant_count;
    longint      cyc;
    logic [31:0] q_addr [$];
    longint      q_due  [$];

    fetch_unit dut (
        .clk           (clk),
        .i_reset       (reset),
        .i_running     (running),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_gnt     (mem_gnt),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata),
        .o_insn_valid  (insn_valid),
        .o_insn        (insn),
        .o_insn_pc     (insn_pc),
        .i_insn_ready  (insn_ready)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_gnt = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grants every request, answers in order after lat cycles.
    always @(negedge clk) begin
        longint due;
        if (reset) begin
            q_addr.delete();
            q_due.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            mem_rvalid = 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc + 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q_addr[0] ^ 32'hE3A0_0000;
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (mem_req && mem_gnt) begin
                due = cyc + 1 + lat;
                if (q_due.size() > 0 && due <= q_due[$]) due = q_due[$] + 1;
                q_addr.push_back(mem_addr);
                q_due.push_back(due);
                grant_count++;
            end
        end
    end

    task automatic apply_stimulus(input logic rst, input logic run, input logic redir,
                                  input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset       = rst;
        running     = run;
        redirect    = redir;
        redirect_pc = rpc;
        insn_ready  = rdy;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (insn_valid !== 1'b1 && n < 40) begin
            apply_stimulus(1'b0, running, 1'b0, 32'h0, insn_ready);
            n++;
        end
        check_output(tag, 32'(insn_valid), 32'd1);
    endtask

    initial begin
        cyc         = 0;
        errors      = 0;
        checks      = 0;
        lat         = 1;
        grant_count = 0;
        reset       = 1'b1;
        running     = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        insn_ready  = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("reset req", 32'(mem_req), 32'd0);
        check_output("reset valid", 32'(insn_valid), 32'd0);
        check_output("reset insn", insn, 32'h0);
        check_output("reset pc", insn_pc, 32'h0);

        $display("[TB] sequential stream");
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("first req", 32'(mem_req), 32'd1);
        check_output("first addr", mem_addr, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("early valid", 32'(insn_valid), 32'd0);
        check_output("second addr", mem_addr, 32'h4);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check_output("stream valid", 32'(insn_valid), 32'd1);
            check_output("stream pc", insn_pc, 32'(k * 4));
            check_output("stream insn", insn, 32'hE3A0_0000 ^ 32'(k * 4));
        end

        $display("[TB] back-pressure fill");
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        grant_count = 0;
        check_output("redirect req low", 32'(mem_req), 32'd0);
        repeat (10) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check_output("fill grants", 32'(grant_count), 32'd4);
        check_output("fill req low", 32'(mem_req), 32'd0);
        check_output("fill head pc", insn_pc, 32'h0000_0200);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check_output("drain valid", 32'(insn_valid), 32'd1);
            check_output("drain pc", insn_pc, 32'h0000_0200 + 32'(k * 4));
        end

        $display("[TB] stale responses with slow memory");
        repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_output("idle valid", 32'(insn_valid), 32'd0);
        lat = 3;
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
        wait_valid("slow redirect valid");
        check_output("slow redirect pc", insn_pc, 32'h0000_0100);
        check_output("slow redirect insn", insn, 32'hE3A0_0100);

        $display("[TB] redirect during gnt and rvalid");
        lat = 1;
        repeat (8) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
        check_output("redir cycle req", 32'(mem_req), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("redir n+1 valid", 32'(insn_valid), 32'd0);
        check_output("redir n+1 req", 32'(mem_req), 32'd1);
        check_output("redir n+1 addr", mem_addr, 32'h0000_0400);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("redir n+2 valid", 32'(insn_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("redir n+3 valid", 32'(insn_valid), 32'd1);
        check_output("redir n+3 pc", insn_pc, 32'h0000_0400);
        check_output("redir n+3 insn", insn, 32'hE3A0_0400);

        $display("[TB] address wrap");
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("wrap pc0", insn_pc, 32'hFFFF_FFF8);
        check_output("wrap insn0", insn, 32'h1C5F_FFF8);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("wrap pc1", insn_pc, 32'hFFFF_FFFC);
        check_output("wrap insn1", insn, 32'h1C5F_FFFC);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("wrap pc2", insn_pc, 32'h0000_0000);
        check_output("wrap insn2", insn, 32'hE3A0_0000);

        $display("[TB] reset mid-transaction");
        lat = 3;
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b0);
        repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_output("rst valid", 32'(insn_valid), 32'd0);
        check_output("rst req", 32'(mem_req), 32'd0);
        check_output("rst insn", insn, 32'h0);
        check_output("rst pc", insn_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check_output("rst perf", perf_stall, 32'h0);
`endif
        lat = 1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("post rst req", 32'(mem_req), 32'd1);
        check_output("post rst addr", mem_addr, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_PERF_EN
        check_output("perf count", perf_stall, 32'd1);
`endif
        wait_valid("post rst valid");
        check_output("post rst pc", insn_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
